instruction_cycle_controller: RTL and testbench

Control-unit FSM that drives the instruction-cycle datapath (IR, PC, PC-increment and address muxes) and the accumulator/memory datapath. It consumes the 3-bit opcode IR[7:5] and status flags, and sequences fetch, decode and execute. A memory ready handshake and an Enter-key wait govern how long each step lasts. It sits beside the datapath as the source of every load and select strobe.

---
 rtl/instruction_cycle_controller_if.sv | 37 +++
 rtl/instruction_cycle_controller.sv | 209 ++++++++++++++++++++
 tb/tb_instruction_cycle_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_cycle_controller_if.sv
// Control/status bundle between the instruction-cycle controller and its datapath.
// The controller side uses the master modport; the datapath side uses slave.
interface instruction_cycle_controller_if;

  // Status from the datapath
  logic [2:0] IR75;
  logic       Aeq0;
  logic       Apos;
  logic       Enter;
  logic       mem_ready;

  // Load and select strobes to the datapath
  logic       IRload;
  logic       PCload;
  logic       IMPsel;
  logic       MeminstSel;
  logic       MemWrite;
  logic       Aload;
  logic [1:0] Asel;
  logic       ALUsel;
  logic       Halt;
  logic [2:0] state;
  logic       mem_err;

  modport master (
    input  IR75, Aeq0, Apos, Enter, mem_ready,
    output IRload, PCload, IMPsel, MeminstSel, MemWrite, Aload, Asel, ALUsel,
           Halt, state, mem_err
  );

  modport slave (
    output IR75, Aeq0, Apos, Enter, mem_ready,
    input  IRload, PCload, IMPsel, MeminstSel, MemWrite, Aload, Asel, ALUsel,
           Halt, state, mem_err
  );

endinterface

// File: rtl/instruction_cycle_controller.sv
// Instruction-cycle control FSM: sequences fetch, decode and execute for an
// accumulator machine and produces every datapath load/select strobe.
// Strobes decode combinationally from the current state, the opcode and the
// handshake inputs, so a strobe gated by mem_ready or Enter fires in the same
// cycle the handshake arrives.
// Optional macro ICC_MEM_TIMEOUT_EN: bounds every memory wait to TIMEOUT
// cycles and enters a sticky FAULT state (mem_err=1, Halt=1) on expiry.
module instruction_cycle_controller #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TW      = 4
) (
  input  logic                           clk,
  input  logic                           clear,
  instruction_cycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    START  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  // Counter must be able to hold TIMEOUT, and a zero timeout is meaningless
  if ((TIMEOUT < 1) || ((2 ** TW) <= TIMEOUT)) begin : g_bad_cfg
    $error("instruction_cycle_controller: need 1 <= TIMEOUT < 2**TW");
  end

  state_t     cur_state;
  state_t     nxt_state;
  logic       timeout_hit;

  logic       ir_load;
  logic       pc_load;
  logic       imp_sel;
  logic       mem_inst_sel;
  logic       mem_write;
  logic       a_load;
  logic [1:0] a_sel;
  logic       alu_sel;
  logic       halt;
  logic       mem_err;

`ifdef ICC_MEM_TIMEOUT_EN
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;
  logic          mem_wait;

  // Memory-wait states: FETCH and the LOAD/STORE/ADD/SUB executes (opcodes 0xx)
  assign mem_wait    = (cur_state == FETCH) || ((cur_state == EXEC) && !bus.IR75[2]);
  // This wait cycle would be the TIMEOUT-th without a handshake
  assign timeout_hit = mem_wait && (tmo_cnt == TMO_LAST);

  // Wait counter: cleared on every state change, counts stalled wait cycles
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      tmo_cnt <= '0;
    end else if (nxt_state != cur_state) begin
      tmo_cnt <= '0;
    end else if (mem_wait && !bus.mem_ready) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cur_state <= START;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    nxt_state    = cur_state;
    ir_load      = 1'b0;
    pc_load      = 1'b0;
    imp_sel      = 1'b0;
    mem_inst_sel = 1'b0;
    mem_write    = 1'b0;
    a_load       = 1'b0;
    a_sel        = ASEL_ALU;
    alu_sel      = 1'b0;
    halt         = 1'b0;
    mem_err      = 1'b0;

    unique case (cur_state)
      START: begin
        nxt_state = FETCH;
      end

      // Instruction read from PC; IR and PC+1 load on the data-valid cycle
      FETCH: begin
        mem_inst_sel = 1'b0;
        if (bus.mem_ready) begin
          ir_load   = 1'b1;
          pc_load   = 1'b1;
          imp_sel   = 1'b0;
          nxt_state = DECODE;
        end else if (timeout_hit) begin
          nxt_state = FAULT;
        end
      end

      // Present the operand address one cycle ahead of execute
      DECODE: begin
        mem_inst_sel = 1'b1;
        nxt_state    = EXEC;
      end

      EXEC: begin
        unique case (bus.IR75)
          OP_LOAD, OP_ADD, OP_SUB: begin
            mem_inst_sel = 1'b1;
            a_sel        = (bus.IR75 == OP_LOAD) ? ASEL_MEM : ASEL_ALU;
            alu_sel      = (bus.IR75 == OP_SUB);
            if (bus.mem_ready) begin
              a_load    = 1'b1;
              nxt_state = FETCH;
            end else if (timeout_hit) begin
              nxt_state = FAULT;
            end
          end

          // Write strobe held until the memory accepts it
          OP_STORE: begin
            mem_inst_sel = 1'b1;
            mem_write    = 1'b1;
            if (bus.mem_ready) begin
              nxt_state = FETCH;
            end else if (timeout_hit) begin
              nxt_state = FAULT;
            end
          end

          // Only the Enter key completes an input; memory is not involved
          OP_INPUT: begin
            a_sel = ASEL_IN;
            if (bus.Enter) begin
              a_load    = 1'b1;
              nxt_state = FETCH;
            end
          end

          OP_JZ, OP_JPOS: begin
            if ((bus.IR75 == OP_JZ) ? bus.Aeq0 : bus.Apos) begin
              pc_load = 1'b1;
              imp_sel = 1'b1;
            end
            nxt_state = FETCH;
          end

          OP_HALT: begin
            nxt_state = HALT;
          end
        endcase
      end

      HALT: begin
        halt = 1'b1;
      end

      FAULT: begin
        halt = 1'b1;
`ifdef ICC_MEM_TIMEOUT_EN
        mem_err = 1'b1;
`endif
      end

      default: begin
        nxt_state = START;
      end
    endcase
  end

  // Drive the bundle
  assign bus.IRload     = ir_load;
  assign bus.PCload     = pc_load;
  assign bus.IMPsel     = imp_sel;
  assign bus.MeminstSel = mem_inst_sel;
  assign bus.MemWrite   = mem_write;
  assign bus.Aload      = a_load;
  assign bus.Asel       = a_sel;
  assign bus.ALUsel     = alu_sel;
  assign bus.Halt       = halt;
  assign bus.state      = cur_state;
  assign bus.mem_err    = mem_err;

endmodule

// File: tb/tb_instruction_cycle_controller.sv
// Scoreboard bench for instruction_cycle_controller: the stimulus process
// drives inputs just after each rising edge and queues the hand-derived
// state/strobe vector for that cycle; the monitor pops and compares on the
// falling edge.
module tb_instruction_cycle_controller;

  // Expected vector layout: {state[2:0], IRload, PCload, IMPsel, MeminstSel,
  // MemWrite, Aload, Asel[1:0], ALUsel, Halt, mem_err}
  localparam logic [10:0] NONE   = 11'b000_0000_0000;
  localparam logic [10:0] IRL    = 11'b100_0000_0000;
  localparam logic [10:0] PCL    = 11'b010_0000_0000;
  localparam logic [10:0] IMP    = 11'b001_0000_0000;
  localparam logic [10:0] MIS    = 11'b000_1000_0000;
  localparam logic [10:0] MW     = 11'b000_0100_0000;
  localparam logic [10:0] AL     = 11'b000_0010_0000;
  localparam logic [10:0] AS_MEM = 11'b000_0001_0000;
  localparam logic [10:0] AS_IN  = 11'b000_0000_1000;
  localparam logic [10:0] ALU    = 11'b000_0000_0100;
  localparam logic [10:0] HLT    = 11'b000_0000_0010;
  localparam logic [10:0] MER    = 11'b000_0000_0001;

  typedef struct {
    string       name;
    logic [13:0] exp;
  } sb_entry_t;

  logic clk;
  logic clear;
  instruction_cycle_controller_if ifc();

  instruction_cycle_controller #(.TIMEOUT(15), .TW(4)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (ifc)
  );

  sb_entry_t sb[$];
  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare one queued expectation per cycle, mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_entry_t e;
      logic [13:0] act;
      e   = sb.pop_front();
      act = {ifc.state, ifc.IRload, ifc.PCload, ifc.IMPsel, ifc.MeminstSel,
             ifc.MemWrite, ifc.Aload, ifc.Asel, ifc.ALUsel, ifc.Halt, ifc.mem_err};
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got state=%0d strobes=%b, expected state=%0d strobes=%b",
                 e.name, act[13:11], act[10:0], e.exp[13:11], e.exp[10:0]);
      end
    end
  end

  task automatic push(input string nm, input logic [2:0] st, input logic [10:0] o);
    sb_entry_t e;
    e.name = nm;
    e.exp  = {st, o};
    sb.push_back(e);
  endtask

  // One cycle: drive inputs just after the rising edge, queue the expectation
  task automatic step(input logic [2:0] ir, input logic aeq, input logic apos,
                      input logic ent, input logic mr, input string nm,
                      input logic [2:0] st, input logic [10:0] o);
    @(posedge clk);
    #1;
    ifc.IR75      = ir;
    ifc.Aeq0      = aeq;
    ifc.Apos      = apos;
    ifc.Enter     = ent;
    ifc.mem_ready = mr;
    push(nm, st, o);
  endtask

  // Zero-wait FETCH followed by DECODE with the opcode already in place
  task automatic head(input logic [2:0] ir);
    step(ir, 1'b0, 1'b0, 1'b0, 1'b1, "fetch", 3'd1, IRL | PCL);
    step(ir, 1'b0, 1'b0, 1'b0, 1'b1, "decode", 3'd2, MIS);
  endtask

  initial begin
    clear         = 1'b0;
    ifc.IR75      = 3'b000;
    ifc.Aeq0      = 1'b0;
    ifc.Apos      = 1'b0;
    ifc.Enter     = 1'b0;
    ifc.mem_ready = 1'b0;

    // Held in reset: START, everything low
    step(3'b000, 1'b1, 1'b1, 1'b1, 1'b1, "in_reset", 3'd0, NONE);

    // Release mid-cycle: this cycle is START
    @(posedge clk);
    #1;
    clear = 1'b1;
    push("start", 3'd0, NONE);

    // LOAD with three memory stall cycles
    head(3'b000);
    for (int i = 0; i < 3; i++)
      step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, "load_wait", 3'd3, MIS | AS_MEM);
    step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, "load_done", 3'd3, MIS | AS_MEM | AL);

    // JZ taken / not taken (Apos must not matter)
    head(3'b101);
    step(3'b101, 1'b1, 1'b0, 1'b0, 1'b1, "jz_taken", 3'd3, PCL | IMP);
    head(3'b101);
    step(3'b101, 1'b0, 1'b1, 1'b0, 1'b1, "jz_not", 3'd3, NONE);

    // JPOS taken / not taken (Aeq0 must not matter)
    head(3'b110);
    step(3'b110, 1'b0, 1'b1, 1'b0, 1'b0, "jpos_taken", 3'd3, PCL | IMP);
    head(3'b110);
    step(3'b110, 1'b1, 1'b0, 1'b0, 1'b1, "jpos_not", 3'd3, NONE);

    // ADD zero-wait, SUB with one stall
    head(3'b010);
    step(3'b010, 1'b0, 1'b0, 1'b0, 1'b1, "add", 3'd3, MIS | AL);
    head(3'b011);
    step(3'b011, 1'b0, 1'b0, 1'b0, 1'b0, "sub_wait", 3'd3, MIS | ALU);
    step(3'b011, 1'b0, 1'b0, 1'b0, 1'b1, "sub_done", 3'd3, MIS | AL | ALU);

    // STORE holds MemWrite through its stalls and the accept cycle
    head(3'b001);
    for (int i = 0; i < 2; i++)
      step(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, "store_wait", 3'd3, MIS | MW);
    step(3'b001, 1'b0, 1'b0, 1'b0, 1'b1, "store_done", 3'd3, MIS | MW);

    // INPUT waits on Enter only, mem_ready high throughout
    head(3'b100);
    for (int i = 0; i < 5; i++)
      step(3'b100, 1'b0, 1'b0, 1'b0, 1'b1, "input_wait", 3'd3, AS_IN);
    step(3'b100, 1'b0, 1'b0, 1'b1, 1'b1, "input_enter", 3'd3, AS_IN | AL);

    // Slow FETCH: 14 stalls, data on the 15th (completes even with timeout)
    for (int i = 0; i < 14; i++)
      step(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, "fetch_wait", 3'd1, NONE);
    step(3'b111, 1'b0, 1'b0, 1'b0, 1'b1, "fetch_late", 3'd1, IRL | PCL);
    step(3'b111, 1'b0, 1'b0, 1'b0, 1'b1, "decode_halt", 3'd2, MIS);
    step(3'b111, 1'b0, 1'b0, 1'b0, 1'b1, "exec_halt", 3'd3, NONE);

    // HALT is sticky while handshakes toggle
    for (int i = 0; i < 20; i++)
      step(3'b111, 1'b0, 1'b0, logic'(i % 2), logic'((i / 2) % 2), "halt_hold", 3'd4, HLT);

    // Clear asserted mid-cycle from HALT: outputs drop before the next edge
    @(posedge clk);
    #3;
    clear = 1'b0;
    push("clear_mid", 3'd0, NONE);
    step(3'b111, 1'b0, 1'b0, 1'b1, 1'b1, "clear_hold", 3'd0, NONE);
    @(posedge clk);
    #1;
    clear = 1'b1;
    push("restart", 3'd0, NONE);

`ifdef ICC_MEM_TIMEOUT_EN
    // Fifteen stalled FETCH cycles, then FAULT which is sticky
    for (int i = 0; i < 15; i++)
      step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, "tmo_wait", 3'd1, NONE);
    for (int i = 0; i < 3; i++)
      step(3'b000, 1'b0, 1'b0, 1'b1, logic'(i % 2), "fault_hold", 3'd5, HLT | MER);
`else
    // No timeout: FETCH stalls indefinitely with mem_err low
    for (int i = 0; i < 20; i++)
      step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, "fetch_unbounded", 3'd1, NONE);
    step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, "fetch_after_long", 3'd1, IRL | PCL);
`endif

    // Let the monitor drain, bounded
    for (int k = 0; k < 10 && sb.size() != 0; k++)
      @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
